nsnrlatch_ctrl: RTL and testbench

Sequencer and arbiter that shares a bank of active-low set/reset latches (nsnrlatch cells) among several requesters. It turns each granted request into a single clean low-going pulse on exactly one `nset` or `nrst` line. It guarantees that no latch ever sees `nset` and `nrst` low together, and that only one line in the bank is active at any time. It sits between control logic and the latch bank, and can optionally read back the latch `q` to flag failed writes.

---
 rtl/nsnrlatch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_nsnrlatch_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nsnrlatch_ctrl.sv
// rtl/nsnrlatch_ctrl.sv - round-robin pulse sequencer for a bank of active-low set/reset latches
// Optional q readback check after each write: define NSNRLATCH_CTRL_VERIFY_EN.
module nsnrlatch_ctrl #(
  parameter int NREQ = 4,
  parameter int NLAT = 8,
  parameter int IW   = 3,
  parameter int PW   = 2,
  parameter int GAP  = 1
) (
  input  logic               ck,
  input  logic               nrst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*IW-1:0] req_idx,
  output logic [NREQ-1:0]    ack,
  output logic [NLAT-1:0]    lat_nset,
  output logic [NLAT-1:0]    lat_nrst,
  input  logic [NLAT-1:0]    lat_q,
  output logic               busy,
  output logic               err
);

  localparam int RW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (PW > GAP) ? PW : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_DONE, S_RECOVER} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [RW-1:0]   r_ptr, w_ptr_nxt;
  logic [RW-1:0]   r_win, w_win_nxt;
  logic            r_op, w_op_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            r_oor, w_oor_nxt;
  logic            w_err_set;
  logic            w_q_bad;
  logic            w_found;
  logic [RW-1:0]   w_pick;
  logic [RW-1:0]   w_cand;
  logic [IW-1:0]   w_pick_idx;
  logic [NLAT-1:0] w_sel;
  logic [NREQ-1:0] w_ack_nxt;
  logic [NLAT-1:0] r_nset, r_nrst;
  logic [NREQ-1:0] r_ack;
  logic            r_busy, r_err;

  function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return RW'(s);
  endfunction

  // Round-robin search starting at the pointer; first asserted requester wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = wrap_add(r_ptr, k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_pick_idx = req_idx[int'(w_pick)*IW +: IW];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_op_nxt    = r_op;
    w_idx_nxt   = r_idx;
    w_oor_nxt   = r_oor;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = CW'(PW - 1);
          w_ptr_nxt   = wrap_add(w_pick, 1);
          w_win_nxt   = w_pick;
          w_op_nxt    = req_op[w_pick];
          w_idx_nxt   = w_pick_idx;
          // Out-of-range grants keep the same ack timing but never drive a line.
          w_oor_nxt   = (int'(w_pick_idx) >= NLAT);
          w_err_set   = w_oor_nxt;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_DONE: begin
        if (GAP > 0) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = CW'((GAP > 0) ? GAP - 1 : 0);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RECOVER: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One-hot line select for the coming cycle; at most one bit can be set.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NLAT; i++) begin
      w_sel[i] = (w_state_nxt == S_PULSE) && !w_oor_nxt && (int'(w_idx_nxt) == i);
    end
  end

  always_comb begin
    w_ack_nxt = '0;
    for (int r = 0; r < NREQ; r++) begin
      w_ack_nxt[r] = (w_state_nxt == S_DONE) && (int'(w_win_nxt) == r);
    end
  end

`ifdef NSNRLATCH_CTRL_VERIFY_EN
  // Sampled on the edge that ends the pulse, when q has had PW cycles to settle.
  assign w_q_bad = (r_state == S_PULSE) && (w_state_nxt == S_DONE) && !r_oor &&
                   (lat_q[r_idx] != r_op);
`else
  logic w_unused_lat_q;
  assign w_unused_lat_q = ^lat_q;
  assign w_q_bad        = 1'b0;
`endif

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_nset  <= '1;
      r_nrst  <= '1;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_op    <= w_op_nxt;
      r_idx   <= w_idx_nxt;
      r_oor   <= w_oor_nxt;
      r_nset  <= ~(w_sel & {NLAT{w_op_nxt}});
      r_nrst  <= ~(w_sel & {NLAT{~w_op_nxt}});
      r_ack   <= w_ack_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_err   <= r_err | w_err_set | w_q_bad;
    end
  end

  assign lat_nset = r_nset;
  assign lat_nrst = r_nrst;
  assign ack      = r_ack;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_nsnrlatch_ctrl.sv
// tb/tb_nsnrlatch_ctrl.sv - directed-vector bench for nsnrlatch_ctrl (NREQ=4, PW=2, GAP=1)
module tb_nsnrlatch_ctrl;

  logic        ck = 1'b0;
  logic        nrst = 1'b0;
  logic [3:0]  req = '0, req_op = '0;
  logic [11:0] req_idx = '0;
  logic [3:0]  ack;
  logic [7:0]  lat_nset, lat_nrst, lat_q;
  logic        busy, err;

  logic [3:0]  req6 = '0, req_op6 = '0;
  logic [11:0] req_idx6 = '0;
  logic [3:0]  ack6;
  logic [5:0]  nset6, nrst6;
  logic [5:0]  q6 = '0;
  logic        busy6, err6;

  int          n_checks = 0, n_errors = 0, cyc = 0;
  logic [7:0]  q_model = '0;
  logic        hold_q2 = 1'b0;
  int          ack_who[64];
  int          ack_cyc[64];
  int          n_acks;

  nsnrlatch_ctrl #(.NREQ(4), .NLAT(8), .IW(3), .PW(2), .GAP(1)) u_dut (
    .ck(ck), .nrst(nrst), .req(req), .req_op(req_op), .req_idx(req_idx), .ack(ack),
    .lat_nset(lat_nset), .lat_nrst(lat_nrst), .lat_q(lat_q), .busy(busy), .err(err)
  );

  nsnrlatch_ctrl #(.NREQ(4), .NLAT(6), .IW(3), .PW(2), .GAP(1)) u_dut6 (
    .ck(ck), .nrst(nrst), .req(req6), .req_op(req_op6), .req_idx(req_idx6), .ack(ack6),
    .lat_nset(nset6), .lat_nrst(nrst6), .lat_q(q6), .busy(busy6), .err(err6)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  // Behavioural latch bank; hold_q2 pins q[2] low to provoke a readback mismatch.
  always @(lat_nset or lat_nrst) begin
    for (int i = 0; i < 8; i++) begin
      if (!lat_nset[i])      q_model[i] = 1'b1;
      else if (!lat_nrst[i]) q_model[i] = 1'b0;
    end
  end
  assign lat_q = hold_q2 ? (q_model & 8'hFB) : q_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge ck) begin
    if (nrst) begin
      check("excl8", 32'($countones(~{lat_nset, lat_nrst}) <= 1), 1);
      check("excl6", 32'($countones(~{nset6, nrst6}) <= 1), 1);
    end
  end

  task automatic serve(input int n_want);
    int budget;
    budget = 200;
    while (n_acks < n_want && budget > 0) begin
      @(negedge ck);
      budget--;
      for (int r = 0; r < 4; r++) begin
        if (ack[r]) begin
          ack_who[n_acks] = r;
          ack_cyc[n_acks] = cyc;
          n_acks++;
          req[r] = 1'b0;
        end
      end
    end
    if (n_acks < n_want) check("ack_timeout", n_acks, n_want);
  endtask

  initial begin
    logic [3:0] seen;
    logic [3:0] mask;

    repeat (2) @(negedge ck);
    check("rst_nset", lat_nset, 8'hFF);
    check("rst_nrst", lat_nrst, 8'hFF);
    check("rst_ack", ack, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    nrst = 1'b1;

    // Single set: requester 1, idx 5
    @(negedge ck);
    req_op[1] = 1'b1; req_idx[5:3] = 3'd5; req[1] = 1'b1;
    @(negedge ck);
    check("set_nset_e0", lat_nset, 8'hDF);
    check("set_busy_e0", busy, 1);
    check("set_ack_e0", ack, 4'h0);
    @(negedge ck);
    check("set_nset_e1", lat_nset, 8'hDF);
    check("set_nrst_e1", lat_nrst, 8'hFF);
    @(negedge ck);
    check("set_nset_e2", lat_nset, 8'hFF);
    check("set_ack_e2", ack, 4'h2);
    req[1] = 1'b0;
    @(negedge ck);
    check("set_ack_e3", ack, 4'h0);
    check("set_busy_e3", busy, 1);
    @(negedge ck);
    check("set_busy_e4", busy, 0);
    check("set_nrst_all", lat_nrst, 8'hFF);
    check("set_q5", q_model[5], 1);

    // Reset in the middle of a pulse on lat_nset[3]
    req_op[2] = 1'b1; req_idx[8:6] = 3'd3; req[2] = 1'b1;
    @(negedge ck);
    check("midrst_pulse", lat_nset, 8'hF7);
    nrst = 1'b0;
    #1;
    check("midrst_nset", lat_nset, 8'hFF);
    check("midrst_nrst", lat_nrst, 8'hFF);
    check("midrst_busy", busy, 0);
    req = '0;
    @(negedge ck);
    nrst = 1'b1;
    seen = '0;
    repeat (6) begin
      @(negedge ck);
      seen = seen | ack;
    end
    check("midrst_no_ack", seen, 4'h0);

    // Round-robin: pointer restarts at 0 after reset
    req_op = 4'hF; req_idx = {3'd3, 3'd2, 3'd1, 3'd0}; req = 4'hF;
    n_acks = 0;
    serve(4);
    for (int i = 0; i < 4; i++) check("rr_order", ack_who[i], i);
    for (int i = 1; i < 4; i++) check("rr_gap", ack_cyc[i] - ack_cyc[i-1], 5);
    req = 4'b0101;
    n_acks = 0;
    serve(2);
    check("rr_re_first", ack_who[0], 0);
    check("rr_re_second", ack_who[1], 2);
    check("rr_re_gap", ack_cyc[1] - ack_cyc[0], 5);

    // Same latch, mixed ops: last acked op decides q
    for (int round = 0; round < 6; round++) begin
      mask = 4'($urandom_range(1, 15));
      req_op = 4'($urandom);
      req_idx = {4{3'd6}};
      req = mask;
      n_acks = 0;
      serve($countones(mask));
      check("same_q_last", q_model[6], req_op[ack_who[n_acks-1]]);
    end
    repeat (3) @(negedge ck);

    // Out-of-range on the 6-latch instance
    req_op6[0] = 1'b1; req_idx6[2:0] = 3'd7; req6[0] = 1'b1;
    @(negedge ck);
    check("oor_nset_e0", nset6, 6'h3F);
    check("oor_err_e0", err6, 1);
    @(negedge ck);
    check("oor_nset_e1", nset6, 6'h3F);
    check("oor_ack_e1", ack6, 4'h0);
    @(negedge ck);
    check("oor_ack_e2", ack6, 4'h1);
    check("oor_nrst_e2", nrst6, 6'h3F);
    req6[0] = 1'b0;
    repeat (5) @(negedge ck);
    check("oor_err_sticky", err6, 1);
    check("oor_busy_end", busy6, 0);

    // Readback mismatch: q[2] held low during a set of latch 2
    hold_q2 = 1'b1;
    req_op[0] = 1'b1; req_idx[2:0] = 3'd2; req[0] = 1'b1;
    @(negedge ck);
    @(negedge ck);
    check("vfy_err_pre", err, 0);
    @(negedge ck);
    check("vfy_ack", ack, 4'h1);
`ifdef NSNRLATCH_CTRL_VERIFY_EN
    check("vfy_err_done", err, 1);
`else
    check("vfy_err_done", err, 0);
`endif
    req[0] = 1'b0;
    hold_q2 = 1'b0;
    repeat (3) @(negedge ck);

    nrst = 1'b0;
    #1;
    check("final_err6", err6, 0);
    check("final_err", err, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 1, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "FAIL global_timeout");
  end

endmodule
